reg_file: RTL and testbench

Architectural register file with register-renaming tags, sitting between the decoder/issue stage and the reorder buffer. It holds the 32 committed register values, records for each register which ROB entry will produce its next value, and resolves both source operands of the instruction being issued, either to a value or to a ROB dependency tag. The ROB drives its issue and commit inputs, and its misprediction flush clears all renaming state.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_read_port.sv | 57 +++++
 rtl/reg_file.sv | 120 ++++++++++++
 tb/tb_reg_file.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing constants and the operand-source encoding used by the
// rename register file and its read ports.
package reg_file_pkg;

  localparam int ROB_BIT  = 4;
  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam int REG_BIT  = 5;
  localparam int REG_NUM  = 1 << REG_BIT;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_REG,
    SRC_COMMIT,
    SRC_ROB,
    SRC_WAIT
  } operand_src_e;

endpackage

// File: rtl/reg_read_port.sv
// One operand read port: resolves a source register to a value or to the
// ROB entry that will produce it.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_BIT = reg_file_pkg::ROB_BIT,
  parameter int REG_BIT = reg_file_pkg::REG_BIT
) (
  input  logic [REG_BIT-1:0] id,
  input  logic [31:0]        reg_value,
  input  logic               reg_busy,
  input  logic [ROB_BIT-1:0] reg_tag,
  input  logic               commit_valid,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,
  input  logic               rob_ready,
  input  logic [31:0]        rob_value,
  output logic               ready,
  output logic [31:0]        value,
  output logic [ROB_BIT-1:0] dep,
  output logic [ROB_BIT-1:0] get_rob_entry
);

  operand_src_e src;

  // The bypass matches on tag alone: a retiring entry is unique in the ROB.
  always_comb begin
    src = SRC_WAIT;
    if (id == '0)
      src = SRC_ZERO;
    else if (!reg_busy)
      src = SRC_REG;
    else if (commit_valid && (commit_rob_entry == reg_tag))
      src = SRC_COMMIT;
    else if (rob_ready)
      src = SRC_ROB;
  end

  always_comb begin
    ready = 1'b1;
    value = '0;
    dep   = '0;
    case (src)
      SRC_ZERO:   value = '0;
      SRC_REG:    value = reg_value;
      SRC_COMMIT: value = commit_value;
      SRC_ROB:    value = rob_value;
      default: begin
        ready = 1'b0;
        dep   = reg_tag;
      end
    endcase
  end

  assign get_rob_entry = reg_tag;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: committed values, busy bits
// and producing-ROB-entry tags, plus two combinational operand read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_BIT = reg_file_pkg::ROB_BIT,
  parameter int REG_BIT = reg_file_pkg::REG_BIT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_valid,
  input  logic [REG_BIT-1:0] issue_rd,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               commit_valid,
  input  logic [REG_BIT-1:0] commit_rd,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic               rs1_ready,
  output logic               rs2_ready,
  output logic [31:0]        rs1_value,
  output logic [31:0]        rs2_value,
  output logic [ROB_BIT-1:0] rs1_dep,
  output logic [ROB_BIT-1:0] rs2_dep,
  output logic [ROB_BIT-1:0] get_rob_entry1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [31:0]        value1,
  input  logic [31:0]        value2
);

  localparam int NUM_REG = 1 << REG_BIT;

  logic [NUM_REG-1:0][31:0]        value_all;
  logic [NUM_REG-1:0]              busy_all;
  logic [NUM_REG-1:0][ROB_BIT-1:0] tag_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 has no storage, so writes and issues to it vanish.
        assign value_all[gi] = '0;
        assign busy_all[gi]  = 1'b0;
        assign tag_all[gi]   = '0;
      end else begin : g_store
        logic [31:0]        value_reg;
        logic               busy_reg;
        logic [ROB_BIT-1:0] tag_reg;
        logic               commit_hit;
        logic               issue_hit;

        assign commit_hit = commit_valid && (commit_rd == REG_BIT'(gi));
        assign issue_hit  = issue_valid && (issue_rd == REG_BIT'(gi));

        always_ff @(posedge clk_in or negedge rst_in) begin
          if (!rst_in) begin
            value_reg <= '0;
            busy_reg  <= 1'b0;
            tag_reg   <= '0;
          end else if (rdy_in) begin
            if (commit_hit)
              value_reg <= commit_value;
            // Flush beats issue beats commit; a stale commit leaves busy set.
            if (clear_up) begin
              busy_reg <= 1'b0;
              tag_reg  <= '0;
            end else if (issue_hit) begin
              busy_reg <= 1'b1;
              tag_reg  <= issue_rob_entry;
            end else if (commit_hit && (tag_reg == commit_rob_entry)) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign value_all[gi] = value_reg;
        assign busy_all[gi]  = busy_reg;
        assign tag_all[gi]   = tag_reg;
      end
    end
  endgenerate

  reg_read_port #(.ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT)) u_port1 (
    .id               (rs1_id),
    .reg_value        (value_all[rs1_id]),
    .reg_busy         (busy_all[rs1_id]),
    .reg_tag          (tag_all[rs1_id]),
    .commit_valid     (commit_valid),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rob_ready        (ready1),
    .rob_value        (value1),
    .ready            (rs1_ready),
    .value            (rs1_value),
    .dep              (rs1_dep),
    .get_rob_entry    (get_rob_entry1)
  );

  reg_read_port #(.ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT)) u_port2 (
    .id               (rs2_id),
    .reg_value        (value_all[rs2_id]),
    .reg_busy         (busy_all[rs2_id]),
    .reg_tag          (tag_all[rs2_id]),
    .commit_valid     (commit_valid),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rob_ready        (ready2),
    .rob_value        (value2),
    .ready            (rs2_ready),
    .value            (rs2_value),
    .dep              (rs2_dep),
    .get_rob_entry    (get_rob_entry2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file against an array-based model of the
// architectural state, plus directed scenarios with literal expectations.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_up;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_entry;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_rob_entry;
  logic [31:0] commit_value;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_value, rs2_value;
  logic [3:0]  rs1_dep, rs2_dep;
  logic [3:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;

  int vectors = 0;
  int errors  = 0;
  bit check_en = 0;

  logic [31:0] m_val  [REG_NUM];
  logic        m_busy [REG_NUM];
  logic [3:0]  m_tag  [REG_NUM];

  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_entry(issue_rob_entry),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
    .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Architectural model: commit writes, issue renames, flush forgets renames.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < REG_NUM; r++) begin
        m_val[r]  <= '0;
        m_busy[r] <= 1'b0;
        m_tag[r]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_valid && commit_rd != 0) begin
        m_val[commit_rd] <= commit_value;
        if (m_tag[commit_rd] == commit_rob_entry)
          m_busy[commit_rd] <= 1'b0;
      end
      if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] <= 1'b1;
        m_tag[issue_rd]  <= issue_rob_entry;
      end
      if (clear_up) begin
        for (int r = 0; r < REG_NUM; r++) begin
          m_busy[r] <= 1'b0;
          m_tag[r]  <= '0;
        end
      end
    end
  end

  task automatic check_operand(input string name, input logic [4:0] id,
                               input logic rr, input logic [31:0] rv,
                               input logic d_ready, input logic [31:0] d_value,
                               input logic [3:0] d_dep, input logic [3:0] d_get);
    logic        e_ready;
    logic [31:0] e_value;
    logic [3:0]  e_dep;
    logic [3:0]  e_get;
    e_get = m_tag[id];
    e_ready = 1'b1;
    e_value = 32'd0;
    e_dep = 4'd0;
    if (id == 0) e_value = 32'd0;
    else if (!m_busy[id]) e_value = m_val[id];
    else if (commit_valid && commit_rob_entry == m_tag[id]) e_value = commit_value;
    else if (rr) e_value = rv;
    else begin
      e_ready = 1'b0;
      e_dep = m_tag[id];
    end
    vectors++;
    if (d_ready !== e_ready || d_value !== e_value || d_dep !== e_dep || d_get !== e_get) begin
      errors++;
      $display("FAIL %s t=%0t id=%0d got ready=%0b value=%h dep=%0d get=%0d, expected ready=%0b value=%h dep=%0d get=%0d",
               name, $time, id, d_ready, d_value, d_dep, d_get, e_ready, e_value, e_dep, e_get);
    end
  endtask

  always begin
    @(negedge clk_in);
    #2;
    if (check_en) begin
      check_operand("model_rs1", rs1_id, ready1, value1, rs1_ready, rs1_value, rs1_dep, get_rob_entry1);
      check_operand("model_rs2", rs2_id, ready2, value2, rs2_ready, rs2_value, rs2_dep, get_rob_entry2);
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else
      $display("ok   %s = %h", name, got);
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear_up = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_rob_entry = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rob_entry = '0; commit_value = '0;
    rs1_id = '0; rs2_id = '0;
    ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] e);
    issue_valid = 1'b1; issue_rd = rd; issue_rob_entry = e;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] e, input logic [31:0] v);
    commit_valid = 1'b1; commit_rd = rd; commit_rob_entry = e; commit_value = v;
  endtask

  function automatic logic [4:0] rand_id();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_in = 1'b0;
    idle();
    rs1_id = 5'd5;
    check_en = 1;
    repeat (2) @(negedge clk_in);
    #3;
    check_lit("reset_rs1_ready", 32'(rs1_ready), 32'd1);
    check_lit("reset_rs1_value", rs1_value, 32'd0);
    check_lit("reset_rs1_dep", 32'(rs1_dep), 32'd0);
    check_lit("reset_rs2_ready", 32'(rs2_ready), 32'd1);

    @(negedge clk_in); rst_in = 1'b1; idle(); do_issue(5'd3, 4'd2);
    @(negedge clk_in); idle(); rs1_id = 5'd3; #3;
    check_lit("busy_x3_ready", 32'(rs1_ready), 32'd0);
    check_lit("busy_x3_dep", 32'(rs1_dep), 32'd2);
    check_lit("busy_x3_get", 32'(get_rob_entry1), 32'd2);
    @(negedge clk_in); idle(); rs1_id = 5'd3; ready1 = 1'b1; value1 = 32'h55; #3;
    check_lit("rob_fwd_ready", 32'(rs1_ready), 32'd1);
    check_lit("rob_fwd_value", rs1_value, 32'h55);
    @(negedge clk_in); idle(); do_commit(5'd3, 4'd2, 32'hDEAD); rs1_id = 5'd3; #3;
    check_lit("bypass_value", rs1_value, 32'hDEAD);
    @(negedge clk_in); idle(); rs1_id = 5'd3; #3;
    check_lit("committed_x3", rs1_value, 32'hDEAD);

    @(negedge clk_in); idle(); do_issue(5'd4, 4'd1);
    @(negedge clk_in); idle(); do_issue(5'd4, 4'd5);
    @(negedge clk_in); idle(); do_commit(5'd4, 4'd1, 32'd7);
    @(negedge clk_in); idle(); rs1_id = 5'd4; #3;
    check_lit("stale_commit_dep", 32'(rs1_dep), 32'd5);
    @(negedge clk_in); idle(); do_commit(5'd4, 4'd5, 32'd9); do_issue(5'd4, 4'd6); rs2_id = 5'd4; #3;
    check_lit("commit_issue_bypass", rs2_value, 32'd9);
    @(negedge clk_in); idle(); rs1_id = 5'd4; #3;
    check_lit("issue_wins_dep", 32'(rs1_dep), 32'd6);
    @(negedge clk_in); idle(); do_commit(5'd4, 4'd6, 32'd11);
    @(negedge clk_in); idle(); rs1_id = 5'd4; #3;
    check_lit("x4_final", rs1_value, 32'd11);

    @(negedge clk_in); idle(); do_issue(5'd6, 4'd3);
    @(negedge clk_in); idle(); do_issue(5'd7, 4'd4);
    @(negedge clk_in); idle(); clear_up = 1'b1; do_issue(5'd8, 4'd7);
    @(negedge clk_in); idle(); rs1_id = 5'd6; rs2_id = 5'd8; #3;
    check_lit("flush_x6_ready", 32'(rs1_ready), 32'd1);
    check_lit("flush_x8_ready", 32'(rs2_ready), 32'd1);
    @(negedge clk_in); idle(); rs1_id = 5'd7; rs2_id = 5'd3; #3;
    check_lit("flush_x7_ready", 32'(rs1_ready), 32'd1);
    check_lit("flush_keeps_x3", rs2_value, 32'hDEAD);

    @(negedge clk_in); idle(); do_issue(5'd9, 4'd8);
    @(negedge clk_in); idle(); rdy_in = 1'b0; do_issue(5'd5, 4'd9);
    do_commit(5'd3, 4'd2, 32'd1); clear_up = 1'b1;
    @(negedge clk_in); idle(); rs1_id = 5'd5; rs2_id = 5'd3; #3;
    check_lit("stall_x5_ready", 32'(rs1_ready), 32'd1);
    check_lit("stall_x3_value", rs2_value, 32'hDEAD);
    @(negedge clk_in); idle(); rs1_id = 5'd9; #3;
    check_lit("stall_x9_dep", 32'(rs1_dep), 32'd8);
    @(negedge clk_in); idle(); do_issue(5'd0, 4'd3);
    @(negedge clk_in); idle(); #3;
    check_lit("x0_ready", 32'(rs1_ready), 32'd1);
    check_lit("x0_get", 32'(get_rob_entry1), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      rst_in = ($urandom_range(0, 399) != 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      clear_up = ($urandom_range(0, 31) == 0);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = rand_id();
      issue_rob_entry = 4'($urandom);
      commit_valid = ($urandom_range(0, 1) == 1);
      commit_rd = rand_id();
      commit_rob_entry = ($urandom_range(0, 1) == 1) ? m_tag[commit_rd] : 4'($urandom);
      commit_value = $urandom;
      rs1_id = rand_id();
      rs2_id = ($urandom_range(0, 3) == 0) ? commit_rd : rand_id();
      ready1 = ($urandom_range(0, 2) == 0);
      ready2 = ($urandom_range(0, 2) == 0);
      value1 = $urandom;
      value2 = $urandom;
    end

    @(negedge clk_in); idle(); rst_in = 1'b1;
    @(negedge clk_in); #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
